urna_teclado: RTL
=================

# urna_teclado

Keypad front-end that drives the vote-entry side of the ballot counter. It collects decimal keypresses into a two-digit candidate code, handles correction and confirmation keys, and replays the code as `digit`/`valid` strobes. It then waits for the counter's `VoteStatus` acknowledgement, and on the end-of-session key raises `finish`. It sits between the debounced keypad scanner and the ballot counter, as the transmitter for the counter's receiving protocol.

## Interface
- `DIGITS`, 2: candidate code length in digits, range 1..4.
- `GAP_CYCLES`, 4: low cycles of `valid` between consecutive digit strobes, minimum 1.
- `TIMEOUT`, 255: cycles allowed for a non-zero `VoteStatus` after the last strobe.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: keypress strobe from the scanner.
- `key_code` in 4: 0–9 digit, 10 CONFIRMA, 11 CORRIGE, 12 FIM, 13–15 ignored.
- `key_ready` out 1: keypress accepted when `key_valid & key_ready`.
- `VoteStatus` in 2: counter result; 00 none, 01 C1, 10 C2, 11 null.
- `digit` out 4: digit value presented to the counter.
- `valid` out 1: one-cycle digit strobe.
- `swap` out 1: one-cycle correction pulse.
- `finish` out 1: end of session, level.
- `busy` out 1: high in SEND and WAIT.
- `vote_done` out 1: one-cycle pulse when a vote is acknowledged.
- `error` out 1: one-cycle pulse on acknowledgement timeout.

## Operation
- Reset values: `key_ready`=1, `digit`=0, `valid`=0, `swap`=0, `finish`=0, `busy`=0, `vote_done`=0, `error`=0. State is IDLE, the buffer is empty, and all counters are 0.
- States: IDLE, COLLECT, SEND, WAIT, CLOSED.
- IDLE:
  - Digit key: store it at buffer[0], count=1, go to COLLECT.
  - FIM: go to CLOSED.
  - CONFIRMA and CORRIGE: ignored.
- COLLECT:
  - Digit key while count<DIGITS: append it, count+1.
  - Digit key while count=DIGITS: dropped, no other effect.
  - CORRIGE: clear the buffer, pulse `swap` for 1 cycle, go to IDLE.
  - CONFIRMA while count=DIGITS: go to SEND.
  - CONFIRMA while count<DIGITS: ignored.
  - FIM: ignored.
- SEND:
  - Digits go out in entry order (first key first).
  - Each digit: `digit` is set and `valid`=1 for exactly 1 cycle, then `GAP_CYCLES` low cycles.
  - `digit` holds its value until the next digit is presented.
  - After the last strobe's gap, go to WAIT.
- WAIT:
  - The timer starts at 0 and `VoteStatus` is sampled each cycle.
  - First non-zero value: pulse `vote_done`, clear the buffer, go to IDLE.
  - Timer reaching TIMEOUT with status still 00: pulse `error`, clear the buffer, go to IDLE.
- CLOSED: `finish`=1 and `key_ready`=0. Only `rst_n` exits this state.
- `key_ready`=1 only in IDLE and COLLECT.
- Keys 13–15 are accepted (handshake completes) and discarded.
- Timer and gap counters saturate and never wrap.

## Timing
- CONFIRMA accepted at cycle N: first `valid` at N+1.
- Strobe k (0-based) is at N+1+k·(GAP_CYCLES+1).
- WAIT is entered at N+1+DIGITS·(GAP_CYCLES+1).
- `VoteStatus` non-zero in WAIT cycle t: `vote_done` pulses at t+1 (registered), and `key_ready` returns that same cycle.
- A `VoteStatus` non-zero already on the WAIT entry cycle counts as an acknowledgement.
- `swap` is asserted the cycle after CORRIGE is accepted.
- `rst_n` low in any state, including mid-SEND: all outputs return to reset values immediately, and any partial strobe sequence is abandoned.
- All outputs are registered with no combinational input-to-output path, except `key_ready`, which is decoded from state.

## Structure
- Shared package `urna_pkg`:
  - Key-code constants: KEY_CONFIRMA=10, KEY_CORRIGE=11, KEY_FIM=12.
  - VoteStatus encodings: ST_NONE, ST_C1, ST_C2, ST_NULL.
  - State enum for this block.
- Sub-module `urna_strobe_gen`: replays an N-digit buffer as `valid` pulses with the gap, with start/done handshake. The top FSM instantiates it for SEND.

## Test plan
- Keys 0, 1, CONFIRMA; `VoteStatus`=01 four cycles after WAIT entry:
  - `valid` pulses at N+1 with `digit`=0 and at N+6 with `digit`=1.
  - `vote_done` pulses once, then IDLE.
- Keys 2, CORRIGE:
  - `swap` pulses 1 cycle and the buffer clears.
  - Keys 0, 2, CONFIRMA then send 0 then 2; keys before CORRIGE never appear.
- Keys 0, 1, 7, CONFIRMA: the 7 is dropped and only 0, 1 are sent.
- Keys 0, 2, CONFIRMA with `VoteStatus` held 00: `error` pulses exactly 255 cycles after WAIT entry and `key_ready` returns to 1.
- FIM in IDLE: `finish`=1 and `key_ready`=0. Further keys have no effect until `rst_n`.
- `rst_n` pulsed low between the first and second strobe: `valid`=0, `busy`=0, state IDLE, and no second strobe.

Source files
------------

// File: rtl/urna_pkg.sv
// urna_pkg: key codes, vote status encodings and FSM states shared by the keypad front-end
package urna_pkg;
  localparam logic [3:0] KEY_CONFIRMA = 4'd10;
  localparam logic [3:0] KEY_CORRIGE = 4'd11;
  localparam logic [3:0] KEY_FIM = 4'd12;
  typedef enum logic [1:0] {ST_NONE, ST_C1, ST_C2, ST_NULL} vote_status_e;
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SEND, S_WAIT, S_CLOSED} urna_state_e;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/urna_teclado_if.sv
// urna_teclado_if: keypad handshake plus the digit/valid link to the ballot counter
interface urna_teclado_if;
  logic key_valid;
  logic [3:0] key_code;
  logic key_ready;
  logic [1:0] VoteStatus;
  logic [3:0] digit;
  logic valid;
  logic swap;
  logic finish;
  logic busy;
  logic vote_done;
  logic error;
  modport master (output key_valid, key_code, VoteStatus,
                  input key_ready, digit, valid, swap, finish, busy, vote_done, error);
  modport slave (input key_valid, key_code, VoteStatus,
                 output key_ready, digit, valid, swap, finish, busy, vote_done, error);
endinterface

// File: rtl/urna_strobe_gen.sv
// urna_strobe_gen: replays a digit buffer as one-cycle valid strobes separated by a fixed gap
module urna_strobe_gen #(
  parameter int DIGITS = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [DIGITS-1:0][3:0] code_buf,
  output logic done,
  output logic [3:0] digit,
  output logic valid
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic active;
  logic [IW-1:0] idx;
  logic [GW-1:0] cnt;
  logic gap_end;
  assign gap_end = active && cnt == GW'(GAP_CYCLES);
  // done is combinational so the caller leaves SEND on the last gap cycle itself
  assign done = gap_end && idx == IW'(DIGITS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      idx <= '0;
      cnt <= '0;
      digit <= '0;
      valid <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      idx <= '0;
      cnt <= '0;
      digit <= code_buf[0];
      valid <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
      valid <= 1'b0;
    end else if (gap_end) begin
      idx <= idx + 1'b1;
      cnt <= '0;
      digit <= code_buf[idx + 1'b1];
      valid <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/urna_teclado.sv
// urna_teclado: keypad front-end collecting a candidate code and sending it to the ballot counter
module urna_teclado
  import urna_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  urna_teclado_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  urna_state_e state;
  logic [DIGITS-1:0][3:0] code_buf;
  logic [CW-1:0] count;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] timer;
  logic accept, start, done;
  assign bus.key_ready = state == S_IDLE || state == S_COLLECT;
  assign accept = bus.key_valid && bus.key_ready;
  assign wr_idx = count[IW-1:0];
  // start is taken straight from the accepted CONFIRMA so the first strobe follows in the next cycle
  assign start = accept && state == S_COLLECT && bus.key_code == KEY_CONFIRMA && count == CW'(DIGITS);
  urna_strobe_gen #(.DIGITS(DIGITS), .GAP_CYCLES(GAP_CYCLES)) u_strobe (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .code_buf(code_buf),
    .done(done),
    .digit(bus.digit),
    .valid(bus.valid)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      code_buf <= '0;
      count <= '0;
      timer <= '0;
      bus.swap <= 1'b0;
      bus.finish <= 1'b0;
      bus.busy <= 1'b0;
      bus.vote_done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      bus.swap <= 1'b0;
      bus.vote_done <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        S_IDLE:
          if (accept && is_digit(bus.key_code)) begin
            code_buf[0] <= bus.key_code;
            count <= CW'(1);
            state <= S_COLLECT;
          end else if (accept && bus.key_code == KEY_FIM) begin
            bus.finish <= 1'b1;
            state <= S_CLOSED;
          end
        S_COLLECT:
          if (start) begin
            bus.busy <= 1'b1;
            state <= S_SEND;
          end else if (accept && bus.key_code == KEY_CORRIGE) begin
            code_buf <= '0;
            count <= '0;
            bus.swap <= 1'b1;
            state <= S_IDLE;
          end else if (accept && is_digit(bus.key_code) && count < CW'(DIGITS)) begin
            code_buf[wr_idx] <= bus.key_code;
            count <= count + 1'b1;
          end
        S_SEND:
          if (done) begin
            timer <= '0;
            state <= S_WAIT;
          end
        S_WAIT:
          if (bus.VoteStatus != ST_NONE || timer == TW'(TIMEOUT - 1)) begin
            bus.vote_done <= bus.VoteStatus != ST_NONE;
            bus.error <= bus.VoteStatus == ST_NONE;
            bus.busy <= 1'b0;
            code_buf <= '0;
            count <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        default: ;
      endcase
    end
  end
endmodule
